// File: rtl/serial_subtract_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and default operand width.
package serial_subtract_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtract.sv
// One-bit full subtractor cell: D = A - B - Bin, Bout set when the difference borrows.
module full_subtract (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Bout,
  output logic D
);

  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtract_ctrl.sv
// Bit-serial a-b controller: one full_subtract cell, LSB first, WIDTH SHIFT cycles per operation.
// Optional macro SUB_OVERFLOW_EN adds the registered two's-complement overflow output.
module serial_subtract_ctrl
  import serial_subtract_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_bin;
  logic [WIDTH-1:0]   r_diff;
  logic               r_borrow;
  logic               r_busy;
  logic               r_done;
  logic               r_ovf;

  logic               w_d;
  logic               w_bout;
  logic               w_last;

  full_subtract u_cell (
    .A    (r_a[0]),
    .B    (r_b[0]),
    .Bin  (r_bin),
    .Bout (w_bout),
    .D    (w_d)
  );

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // Operand registers shift right so bit 0 always presents the current bit pair to the cell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_bin    <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_bin   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_diff <= {w_d, r_diff[WIDTH-1:1]};
          r_bin  <= w_bout;
          r_a    <= r_a >> 1;
          r_b    <= r_b >> 1;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (w_last) begin
            // On the last bit, r_a[0]/r_b[0] are the original sign bits and w_d is the result sign.
            r_borrow <= w_bout;
            r_ovf    <= (r_a[0] != r_b[0]) && (w_d != r_a[0]);
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign diff   = r_diff;
  assign borrow = r_borrow;

`ifdef SUB_OVERFLOW_EN
  assign overflow = r_ovf;
`else
  logic w_ovf_unused;
  assign w_ovf_unused = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// Randomised self-checking bench for serial_subtract_ctrl with an arithmetic reference model.
module tb_serial_subtract_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;

  serial_subtract_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow)
`ifdef SUB_OVERFLOW_EN
    ,
    .overflow (ovf)
`endif
  );

`ifndef SUB_OVERFLOW_EN
  assign ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: edge count, last accepted edge, and the arithmetic result of that operation.
  int           cyc = 0;
  int           acc = -1;
  logic [W-1:0] m_diff = '0;
  logic         m_bor = 1'b0;
  logic         m_ovf = 1'b0;

  always @(negedge rst_n) begin
    acc    = -1;
    m_diff = '0;
    m_bor  = 1'b0;
    m_ovf  = 1'b0;
  end

  always @(posedge clk) begin
    cyc++;
    if (rst_n && start && (acc < 0 || cyc >= acc + W + 2)) begin
      acc    = cyc;
      m_diff = W'(a - b);
      m_bor  = (a < b);
      m_ovf  = (a[W-1] != b[W-1]) && (m_diff[W-1] != a[W-1]);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_busy;
      bit exp_done;
      exp_busy = (acc >= 0) && (cyc >= acc) && (cyc <= acc + W - 1);
      exp_done = (acc >= 0) && (cyc == acc + W);
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      if (!exp_busy) begin
        chk("diff", 32'(diff), 32'(m_diff));
        chk("borrow", 32'(borrow), 32'(m_bor));
`ifdef SUB_OVERFLOW_EN
        chk("overflow", 32'(ovf), 32'(m_ovf));
`endif
      end
    end
  end

  int lat;
  int n_done;

  task automatic wait_done(output int latency);
    latency = 0;
    for (int i = 1; i <= W + 6; i++) begin
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      if (done) begin
        latency = i;
        break;
      end
    end
    if (latency == 0) chk("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, output int latency);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    wait_done(latency);
  endtask

  task automatic count_done(input int ncyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_diff", 32'(diff), 32'(0));
    chk("rst_borrow", 32'(borrow), 32'(0));
    rst_n = 1'b1;
    chk_en = 1'b1;

    do_op(8'h05, 8'h03, lat);
    chk("lat_5_3", 32'(lat), 32'(W + 1));
    chk("diff_5_3", 32'(diff), 32'h02);
    chk("bor_5_3", 32'(borrow), 32'(0));

    do_op(8'h03, 8'h05, lat);
    chk("diff_3_5", 32'(diff), 32'hFE);
    chk("bor_3_5", 32'(borrow), 32'(1));

    do_op(8'hFF, 8'hFF, lat);
    chk("diff_ff_ff", 32'(diff), 32'h00);
    chk("bor_ff_ff", 32'(borrow), 32'(0));

    do_op(8'h00, 8'h01, lat);
    chk("diff_0_1", 32'(diff), 32'hFF);
    chk("bor_0_1", 32'(borrow), 32'(1));

    do_op(8'h80, 8'h01, lat);
    chk("diff_80_1", 32'(diff), 32'h7F);
    chk("bor_80_1", 32'(borrow), 32'(0));
`ifdef SUB_OVERFLOW_EN
    chk("ovf_80_1", 32'(ovf), 32'(1));
`endif

    do_op(8'h7F, 8'hFF, lat);
    chk("diff_7f_ff", 32'(diff), 32'h80);
    chk("bor_7f_ff", 32'(borrow), 32'(1));
`ifdef SUB_OVERFLOW_EN
    chk("ovf_7f_ff", 32'(ovf), 32'(1));
`endif

    // A second start three cycles into an operation must be dropped.
    @(negedge clk);
    a = 8'h40; b = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'h01; b = 8'h02; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    count_done(2 * W + 4, n_done);
    chk("ignored_start_dones", 32'(n_done), 32'(1));
    chk("ignored_start_diff", 32'(diff), 32'h2F);

    // Reset pulse in the fourth SHIFT cycle aborts the operation.
    @(negedge clk);
    a = 8'h20; b = 8'h03; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_diff", 32'(diff), 32'(0));
    chk("abort_borrow", 32'(borrow), 32'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    count_done(W + 4, n_done);
    chk("abort_no_done", 32'(n_done), 32'(0));
    do_op(8'h10, 8'h01, lat);
    chk("post_rst_diff", 32'(diff), 32'h0F);
    chk("post_rst_lat", 32'(lat), 32'(W + 1));

    // start held high: back-to-back operations every W+2 cycles.
    @(negedge clk);
    start = 1'b1;
    n_done = 0;
    for (int i = 0; i < 5 * (W + 2); i++) begin
      @(negedge clk);
      a = W'($urandom);
      b = W'($urandom);
      if (done) n_done++;
    end
    start = 1'b0;
    chk("held_start_dones", 32'(n_done), 32'(5));
    repeat (W + 4) @(negedge clk);

    // Random traffic, including equal operands and mid-operation operand changes.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? a : W'($urandom);
    end
    start = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
